mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS core.
- Sits beside the EX-stage ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs a multi-cycle radix-2 shift-add (multiply) or restoring shift-subtract (divide) loop.
- Raises busy so the hazard unit can stall MFHI/MFLO and further mult/div issues.

Parameters:
- DATA_W, 32: operand width; hi/lo width; iteration count equals DATA_W.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  issue strobe from EX; sampled on the clk edge.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is a no-op.
- in_1  in  DATA_W  rs operand (multiplicand/dividend; MTHI/MTLO data).
- in_2  in  DATA_W  rt operand (multiplier/divisor).
- busy  out  1  registered; high whenever state != IDLE.
- done  out  1  registered one-cycle pulse in the first IDLE cycle after FIX.
- hi  out  DATA_W  HI register (product high word / remainder).
- lo  out  DATA_W  LO register (product low word / quotient).

Behaviour:
- Reset (asynchronous, takes effect at any time including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all working registers cleared.
- Whenever busy=1, start is ignored entirely; hi/lo hold their old values until FIX completes.
- FSM transitions:
  - IDLE: on start with op in {MULT, MULTU, DIV, DIVU}, latch operand magnitudes (signed ops take the absolute value; 0x80000000 stays 0x80000000 as an unsigned magnitude), latch the sign flags and a div-by-zero flag, set counter=0, go to CALC.
  - IDLE: on start with MTHI, write hi<=in_1 at that edge and stay in IDLE. MTLO writes lo<=in_1 the same way. Neither asserts busy or done.
  - IDLE: on start with op 11x, no effect.
  - CALC: one iteration per cycle. Multiply: 2*DATA_W-bit accumulator; if the multiplier LSB is set, add the multiplicand to the upper half, then shift right 1. Divide: shift {rem,quot} left 1; if rem >= divisor, subtract and set the quot LSB.
  - CALC: leave for FIX when counter == DATA_W-1.
  - FIX: apply sign correction and load hi/lo at the FIX edge, then go to IDLE with done=1 for exactly one cycle.
    - Signed multiply: negate the 2*DATA_W product if the operand signs differ.
    - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Latency: start sampled at edge T; busy=1 in cycles T+1..T+DATA_W+1 (33 cycles at default); new hi/lo and done=1 visible in cycle T+DATA_W+2.
- Boundary conditions:
  - Divide by zero (DIV or DIVU): the loop still runs full latency, then lo=all ones, hi=in_1 as originally supplied (raw, not the magnitude).
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - start held high across completion: a new op is accepted in the first IDLE cycle (the done cycle). No back-to-back acceptance occurs in FIX.
- Arithmetic is modulo 2^(2*DATA_W) for the product and modulo 2^DATA_W elsewhere. No exceptions are raised.

Decomposition:
- Package mdu_pkg holds:
  - op code localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - FSM state encoding (S_IDLE, S_CALC, S_FIX);
  - DATA_W default.
- One combinational sub-module, mdu_step, computes a single multiply or divide iteration: inputs are the accumulator, operand and mode; output is the next accumulator.
- mdu_seq owns the FSM, counter, sign/zero flags and hi/lo.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 0x00001234 / 0 -> after 33 busy cycles lo=0xFFFFFFFF, hi=0x00001234.
- MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles -> hi/lo update the next cycle, busy stays 0. A MULTU issued mid-CALC (start=1, op=001) is ignored and the result of the first op is unchanged.
- reset_n low in CALC cycle 10 -> busy=0, done=0, hi=lo=0 immediately (asynchronous). After release, a fresh DIVU 100 / 7 gives lo=14, hi=2.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - op codes presented on mdu_seq.op
//   - FSM state type
//   - default operand width
package mdu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  // True for the four ops that run the iterative loop.
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Signed variants (MULT, DIV) have op[0] clear.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration.
//   acc      in  2*DATA_W  working accumulator
//                multiply: {partial product, remaining multiplier bits}
//                divide:   {partial remainder, dividend/quotient bits}
//   opnd     in  DATA_W    multiplicand (multiply) or divisor (divide) magnitude
//   is_div   in  1         0 = shift-add multiply, 1 = restoring divide
//   acc_next out 2*DATA_W  accumulator after this iteration
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [2*DATA_W-1:0] acc,
  input  logic [DATA_W-1:0]   opnd,
  input  logic                is_div,
  output logic [2*DATA_W-1:0] acc_next
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;

  always_comb begin
    // Multiply: the add carry becomes the top bit after the right shift.
    sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shifted remainder needs one extra bit before the compare;
    // when it is >= divisor the difference always fits in DATA_W bits.
    trial = acc[2*DATA_W-1:DATA_W-1];
    diff  = trial[DATA_W-1:0] - opnd;
    if (is_div) begin
      if (trial >= {1'b0, opnd}) begin
        acc_next = {diff, acc[DATA_W-2:0], 1'b1};
      end else begin
        acc_next = {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer owning the HI/LO pair.
//   clk      in  1       core clock, rising edge
//   reset_n  in  1       asynchronous active-low reset
//   start    in  1       issue strobe, ignored while busy
//   op       in  3       MULT/MULTU/DIV/DIVU/MTHI/MTLO, 11x = no-op
//   in_1     in  DATA_W  rs operand (multiplicand/dividend, MTHI/MTLO data)
//   in_2     in  DATA_W  rt operand (multiplier/divisor)
//   busy     out 1       high while an operation is in CALC or FIX
//   done     out 1       one-cycle pulse in the first IDLE cycle after FIX
//   hi       out DATA_W  HI register (product high / remainder)
//   lo       out DATA_W  LO register (product low / quotient)
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   raw_1;
  logic                is_div;
  logic                neg_res;
  logic                neg_rem;
  logic                div0;

  logic                sgn;
  logic [DATA_W-1:0]   mag_1;
  logic [DATA_W-1:0]   mag_2;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    sgn   = is_signed_op(op);
    mag_1 = (sgn && in_1[DATA_W-1]) ? -in_1 : in_1;
    mag_2 = (sgn && in_2[DATA_W-1]) ? -in_2 : in_2;
  end

  always_comb begin
    prod   = neg_res ? -acc : acc;
    quot   = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    rem    = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    fix_hi = prod[2*DATA_W-1:DATA_W];
    fix_lo = prod[DATA_W-1:0];
    if (is_div) begin
      if (div0) begin
        fix_hi = raw_1;
        fix_lo = '1;
      end else begin
        fix_hi = rem;
        fix_lo = quot;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      raw_1   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (is_arith(op)) begin
              // Multiply keeps the multiplier in the low half and adds the
              // multiplicand; divide keeps the dividend low and subtracts.
              if (op[1]) begin
                acc  <= {{DATA_W{1'b0}}, mag_1};
                opnd <= mag_2;
              end else begin
                acc  <= {{DATA_W{1'b0}}, mag_2};
                opnd <= mag_1;
              end
              is_div  <= op[1];
              neg_res <= sgn && (in_1[DATA_W-1] ^ in_2[DATA_W-1]);
              neg_rem <= sgn && in_1[DATA_W-1];
              div0    <= op[1] && (in_2 == '0);
              raw_1   <= in_1;
              cnt     <= '0;
              state   <= S_CALC;
              busy    <= 1'b1;
            end else if (op == OP_MTHI) begin
              hi <= in_1;
            end else if (op == OP_MTLO) begin
              lo <= in_1;
            end
          end
        end
        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq. Stimulus pushes the expected
// {hi, lo} for each accepted op; a monitor pops and compares on done.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    string          name;
    logic [W-1:0]   h;
    logic [W-1:0]   l;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   bc;
  logic prev_done = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mdu_seq #(.DATA_W(W), .CNT_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .in_1    (in_1),
    .in_2    (in_2),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare outputs against the scoreboard whenever done pulses.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      n_done++;
      check("done_width", {31'b0, prev_done}, '0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, hi=0x%08h lo=0x%08h", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_hi"}, hi, e.h);
        check({e.name, "_lo"}, lo, e.l);
      end
    end
    prev_done = done;
  end

  // Issue one op, then count busy cycles until it drops (bounded). With
  // inject_at > 0, a stray MULTU start is driven at that busy cycle and
  // hi/lo are checked to still hold hold_hi/hold_lo.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input string name,
                       input int inject_at, input logic [W-1:0] hold_hi,
                       input logic [W-1:0] hold_lo, output int cycles);
    exp_t e;
    cycles = 0;
    @(negedge clk);
    start = 1'b1; op = o; in_1 = a; in_2 = b;
    e.name = name; e.h = eh; e.l = el;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    while (busy && cycles < 100) begin
      cycles++;
      if (inject_at != 0 && cycles == inject_at) begin
        start = 1'b1; op = OP_MULTU; in_1 = 32'd7; in_2 = 32'd9;
        check({name, "_hold_hi"}, hi, hold_hi);
        check({name, "_hold_lo"}, lo, hold_lo);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (cycles >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still high after %0d cycles, required drop", name, cycles);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    bit got;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; in_1 = '0; in_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, '0);
    check("rst_done", {31'b0, done}, '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    reset_n = 1'b1;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, '0, '0, bc);
    check("multu_busy_cycles", bc, 32'd33);
    check("multu_done_count", n_done, 32'd1);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0, '0, '0, bc);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min", 0, '0, '0, bc);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0, '0, '0, bc);
    do_op(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2", 0, '0, '0, bc);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0, '0, '0, bc);
    do_op(OP_DIV, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, "div_zero", 0, '0, '0, bc);
    check("div0_busy_cycles", bc, 32'd33);
    check("done_count_7", n_done, 32'd7);

    // MTHI / MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; in_1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_busy", {31'b0, busy}, '0);
    op = OP_MTLO; in_1 = 32'h0BAD_F00D;
    @(posedge clk); #1;
    check("mtlo_lo", lo, 32'h0BAD_F00D);
    check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
    check("mtlo_busy", {31'b0, busy}, '0);
    check("mtlo_done", {31'b0, done}, '0);
    start = 1'b0;
    op = 3'b110; in_1 = 32'h1111_1111;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("noop_busy", {31'b0, busy}, '0);
    check("noop_hi", hi, 32'hDEAD_BEEF);
    check("noop_lo", lo, 32'h0BAD_F00D);

    // MULT with a stray MULTU start mid-CALC
    do_op(OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, "mult_inject", 5, 32'hDEAD_BEEF, 32'h0BAD_F00D, bc);
    check("inject_busy_cycles", bc, 32'd33);
    check("inject_done_count", n_done, 32'd8);
    repeat (2) @(posedge clk);
    #1;
    check("inject_no_restart", {31'b0, busy}, '0);

    // start held high across completion: re-accepted in the done cycle
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; in_1 = 32'd3; in_2 = 32'd5;
    sb_q.push_back('{name: "held_1", h: 32'd0, l: 32'd15});
    sb_q.push_back('{name: "held_2", h: 32'd0, l: 32'd15});
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL held_timeout: no done within 100 cycles, required one");
    end
    check("held_busy_in_done", {31'b0, busy}, '0);
    @(posedge clk); #1;
    check("held_reaccept", {31'b0, busy}, 32'd1);
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(posedge clk); #1;
    end
    check("held_busy_cycles", bc, 32'd33);
    @(negedge clk); #1;
    check("held_done_count", n_done, 32'd10);

    // asynchronous reset during CALC
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; in_1 = 32'd1000; in_2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, '0);
    check("arst_done", {31'b0, done}, '0);
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu_after_rst", 0, '0, '0, bc);
    check("post_rst_busy_cycles", bc, 32'd33);
    check("final_done_count", n_done, 32'd11);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
